// File: rtl/line_writeback_engine_pkg.sv
// line_writeback_engine_pkg: shared FSM states and burst geometry for the line writeback engine.
package line_writeback_engine_pkg;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, BURST, DONE} wb_state_t;
  localparam int NUM_BEATS = 4;
  localparam int BURST_WIDTH = 64;
  localparam int LINE_WIDTH = 256;
  localparam int BEAT_W = $clog2(NUM_BEATS);
endpackage

// File: rtl/line_writeback_engine_shift_out.sv
// line_writeback_engine_shift_out: holds the captured line and selects the current burst beat.
module line_writeback_engine_shift_out
  import line_writeback_engine_pkg::*;
#(
  parameter int line_width = LINE_WIDTH,
  parameter int burst_width = BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   busy,
  input  logic                   adv,
  input  logic [line_width-1:0]  line_in,
  output logic [burst_width-1:0] wdata,
  output logic                   last
);
  logic [line_width-1:0] line_r;
  logic [BEAT_W-1:0]     beat;
  // beat only counts while bursting, so it is back at zero whenever a new burst starts
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r <= '0;
      beat   <= '0;
    end else begin
      if (load) line_r <= line_in;
      beat <= busy ? beat + BEAT_W'(adv) : '0;
    end
  end
  assign wdata = line_r[int'(beat)*burst_width +: burst_width];
  assign last  = beat == BEAT_W'(NUM_BEATS - 1);
endmodule

// File: rtl/line_writeback_engine.sv
// line_writeback_engine: reads one dirty line from the cache arrays and writes it to pmem as a 4-beat burst.
module line_writeback_engine
  import line_writeback_engine_pkg::*;
#(
  parameter int s_index = 3,
  parameter int s_offset = 5,
  parameter int s_tag = 32 - s_offset - s_index,
  parameter int line_width = LINE_WIDTH,
  parameter int burst_width = BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_req,
  input  logic [s_index-1:0]     wb_index,
  input  logic [s_tag-1:0]       wb_tag,
  output logic                   wb_ready,
  output logic                   wb_done,
  output logic                   arr_read,
  output logic [s_index-1:0]     arr_index,
  input  logic [line_width-1:0]  arr_dataout,
  output logic [31:0]            pmem_address,
  output logic                   pmem_write,
  output logic [burst_width-1:0] pmem_wdata,
  input  logic                   pmem_resp
);
  wb_state_t          state, next;
  logic [s_index-1:0] idx_r;
  logic [s_tag-1:0]   tag_r;
  logic               last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_r <= '0;
      tag_r <= '0;
    end else begin
      state <= next;
      if (state == IDLE && wb_req) begin
        idx_r <= wb_index;
        tag_r <= wb_tag;
      end
    end
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = wb_req ? READ : IDLE;
      READ:    next = CAPTURE;
      CAPTURE: next = BURST;
      BURST:   next = (pmem_resp && last) ? DONE : BURST;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // every output is a decode of registered state, keeping pmem_resp and wb_req off output paths
  assign wb_ready     = state == IDLE;
  assign wb_done      = state == DONE;
  assign arr_read     = state == READ;
  assign pmem_write   = state == BURST;
  assign arr_index    = idx_r;
  assign pmem_address = {tag_r, idx_r, {s_offset{1'b0}}};
  line_writeback_engine_shift_out #(
    .line_width (line_width),
    .burst_width(burst_width)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load   (state == CAPTURE),
    .busy   (state == BURST),
    .adv    (pmem_resp),
    .line_in(arr_dataout),
    .wdata  (pmem_wdata),
    .last   (last)
  );
endmodule
